unidad_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the RISC-V M-extension operations for the datapath. It consumes the two operand values read from the register bank (`rd1`/`rd2`) and produces the register write-back triple (`a3`, `wd3`, `we`) consumed by the bank. While an operation is in flight, `busy` stalls the rest of the core.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/unidad_muldiv_if.sv | 28 ++
 rtl/unidad_muldiv_div_iter.sv | 44 ++++
 rtl/unidad_muldiv.sv | 156 +++++++++++++++
 tb/tb_unidad_muldiv.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: default width,
// RISC-V M-extension funct3 codes and FSM state encoding.
package muldiv_pkg;

    localparam int DEFAULT_XLEN = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

endpackage

// File: rtl/unidad_muldiv_if.sv
// Request/response bundle between the datapath (master) and the
// multiply/divide unit (slave).
interface unidad_muldiv_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we;

    modport master (
        output start, op, rs1_val, rs2_val, rd_in,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_in,
        output busy, done, result, rd_out, we
    );
endinterface

// File: rtl/unidad_muldiv_div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per enabled cycle.
// Only instantiated when MDU_DIV_EN is defined.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            en,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    logic [XLEN-1:0] dvsr;
    logic [XLEN:0]   trial;
    logic [XLEN:0]   diff;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    always_comb begin
        trial = {remainder, quotient[XLEN-1]};
        diff  = trial - {1'b0, dvsr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            dvsr      <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            dvsr      <= divisor;
        end else if (en) begin
            if (!diff[XLEN]) begin
                remainder <= diff[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b1};
            end else begin
                remainder <= trial[XLEN-1:0];
                quotient  <= {quotient[XLEN-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/unidad_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiplier inline, restoring
// divider in div_iter. Define MDU_DIV_EN to build the divide path.
module unidad_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input logic             clk,
    input logic             rst,
    unidad_muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              special_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand;
    logic              busy_q, done_q, we_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              is_special;
    logic [XLEN-1:0]   special_val;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic              accept;

    assign accept = (state == S_IDLE) && bus.start;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        a_signed = bus.op[2] ? ~bus.op[0] : (bus.op != OP_MULHU);
        b_signed = bus.op[2] ? ~bus.op[0] : ~bus.op[1];
        a_neg    = a_signed & bus.rs1_val[XLEN-1];
        b_neg    = b_signed & bus.rs2_val[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_val : bus.rs1_val;
        b_mag    = b_neg ? -bus.rs2_val : bus.rs2_val;
`ifdef MDU_DIV_EN
        is_special  = bus.op[2] && ((bus.rs2_val == '0) ||
                      (a_signed && bus.rs1_val == INT_MIN && bus.rs2_val == '1));
        special_val = (bus.rs2_val == '0) ? (bus.op[1] ? bus.rs1_val : '1)
                                          : (bus.op[1] ? '0 : INT_MIN);
`else
        is_special  = bus.op[2];
        special_val = '0;
`endif
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_fix = neg_q ? -prod : prod;
    end

`ifdef MDU_DIV_EN
    logic            rem_neg_q;
    logic [XLEN-1:0] quo, rem;

    div_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && bus.op[2] && !is_special),
        .en        (state == S_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rem_neg_q <= 1'b0;
        else if (accept) rem_neg_q <= a_neg;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            prod      <= '0;
            mcand     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
            result_q  <= '0;
            rd_q      <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    op_q      <= bus.op;
                    rd_q      <= bus.rd_in;
                    neg_q     <= a_neg ^ b_neg;
                    special_q <= is_special;
                    cnt       <= '0;
                    busy_q    <= 1'b1;
                    if (is_special) begin
                        prod  <= {{XLEN{1'b0}}, special_val};
                        state <= S_FIX;
                    end else if (bus.op[2]) begin
                        state <= S_DIV;
                    end else begin
                        prod  <= {{XLEN{1'b0}}, b_mag};
                        mcand <= a_mag;
                        state <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(XLEN-1)) state <= S_FIX;
                end
`ifdef MDU_DIV_EN
                S_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(XLEN-1)) state <= S_FIX;
                end
`endif
                S_FIX: begin
                    if (special_q)
                        result_q <= prod[XLEN-1:0];
`ifdef MDU_DIV_EN
                    else if (op_q[2])
                        result_q <= op_q[1] ? (rem_neg_q ? -rem : rem)
                                            : (neg_q ? -quo : quo);
`endif
                    else if (op_q == OP_MUL)
                        result_q <= prod_fix[XLEN-1:0];
                    else
                        result_q <= prod_fix[2*XLEN-1:XLEN];
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    we_q   <= (rd_q != 5'd0);
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    we_q   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.we     = we_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_unidad_muldiv.sv
// Scoreboard bench for unidad_muldiv: stimulus pushes expected write-backs,
// a negedge monitor pops and compares on every done pulse.
module tb_unidad_muldiv;
    import muldiv_pkg::*;

    localparam int XLEN = DEFAULT_XLEN;

    typedef struct {
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            we;
        int unsigned     done_cyc;
        string           name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    exp_t        cur;

    unidad_muldiv_if #(.XLEN(XLEN)) bus ();

    unidad_muldiv #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(bus.done), 64'd0);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_result"}, 64'(bus.result), 64'(cur.result));
                    check({cur.name, "_rd"},     64'(bus.rd_out), 64'(cur.rd));
                    check({cur.name, "_we"},     64'(bus.we),     64'(cur.we));
                    check({cur.name, "_cycle"},  64'(cyc),        64'(cur.done_cyc));
                    check({cur.name, "_busy_low"}, 64'(bus.busy), 64'd0);
                end
            end else if (sb.size() != 0) begin
                check({sb[0].name, "_busy"}, 64'(bus.busy), 64'd1);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [4:0] rd, input logic [XLEN-1:0] exp_res,
                         input bit special, input string name);
        exp_t e;
`ifndef MDU_DIV_EN
        if (op[2]) begin
            exp_res = '0;
            special = 1'b1;
        end
`endif
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd_in   = rd;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rs1_val = ~a;
        bus.rs2_val = ~b;
        bus.rd_in   = ~rd;
        e.result   = exp_res;
        e.rd       = rd;
        e.we       = (rd != 5'd0);
        e.done_cyc = cyc + (special ? 1 : XLEN + 1);
        e.name     = name;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 4 * XLEN && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [4:0] rd, input logic [XLEN-1:0] exp_res,
                       input bit special, input string name);
        issue(op, a, b, rd, exp_res, special, name);
        wait_done();
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd_in   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy",   64'(bus.busy),   64'd0);
        check("reset_done",   64'(bus.done),   64'd0);
        check("reset_we",     64'(bus.we),     64'd0);
        check("reset_result", 64'(bus.result), 64'd0);
        check("reset_rd",     64'(bus.rd_out), 64'd0);
        rst = 1'b0;

        run(OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b0, "mul_7_m3");
        run(OP_MULH,   32'h80000000, 32'h80000000, 5'd1, 32'h40000000, 1'b0, "mulh_min");
        run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 1'b0, "mulhu_max");
        run(OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3, 32'hFFFFFFFF, 1'b0, "mulhsu_m1_2");
        run(OP_DIV,    32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFD, 1'b0, "div_m7_2");
        run(OP_REM,    32'hFFFFFFF9, 32'd2,        5'd4, 32'hFFFFFFFF, 1'b0, "rem_m7_2");
        run(OP_DIVU,   32'd7,        32'd2,        5'd8, 32'd3,        1'b0, "divu_7_2");
        run(OP_REMU,   32'd7,        32'd2,        5'd9, 32'd1,        1'b0, "remu_7_2");
        run(OP_DIV,    32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1'b1, "div_by0");
        run(OP_REM,    32'd5,        32'd0,        5'd11, 32'd5,        1'b1, "rem_by0");
        run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1'b1, "div_ovf");
        run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1'b1, "rem_ovf");

        // Second start during busy must be dropped without a second done.
        issue(OP_MUL, 32'd6, 32'd7, 5'd6, 32'd42, 1'b0, "mul_ignore_start");
        repeat (4) @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_MULHU;
        bus.rs1_val = 32'hFFFFFFFF;
        bus.rs2_val = 32'hFFFFFFFF;
        bus.rd_in   = 5'd20;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (XLEN + 5) @(posedge clk);

        // Reset mid-operation abandons it with no done.
        issue(OP_MUL, 32'd9, 32'd9, 5'd14, 32'd81, 1'b0, "mul_reset");
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb.delete();
        check("midrst_busy",   64'(bus.busy),   64'd0);
        check("midrst_done",   64'(bus.done),   64'd0);
        check("midrst_we",     64'(bus.we),     64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        check("midrst_rd",     64'(bus.rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (XLEN + 5) @(posedge clk);

        run(OP_MULHU, 32'h12345678, 32'h00000010, 5'd7, 32'h00000001, 1'b0, "mulhu_after_rst");
        run(OP_MUL,   32'd3,        32'd4,        5'd0, 32'd12,       1'b0, "mul_rd0");
        run(OP_DIVU,  32'd7,        32'd2,        5'd15, 32'd3,       1'b0, "divu_again");
        run(OP_MUL,   32'd6,        32'd7,        5'd16, 32'd42,      1'b0, "mul_6_7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
